// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths and constants for the WB-stage register file.
package wb_regfile_pkg;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int AW        = 5;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam int TR_PC_W   = XLEN;
    localparam int TR_REG_W  = AW;
    localparam int TR_DATA_W = XLEN;
endpackage

// File: rtl/wb_regfile_trace.sv
// wb_trace: registered retire/trace record and retire/write counters.
module wb_trace
    import wb_regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TR_PC_W-1:0]   pc_i,
    input  logic [TR_REG_W-1:0]  a3_i,
    input  logic [TR_DATA_W-1:0] wd_i,
    input  logic                 we_i,
    output logic                 tr_valid_o,
    output logic [TR_PC_W-1:0]   tr_pc_o,
    output logic [TR_REG_W-1:0]  tr_reg_o,
    output logic [TR_DATA_W-1:0] tr_data_o,
    output logic [XLEN-1:0]      retire_cnt_o,
    output logic [XLEN-1:0]      write_cnt_o
);
    logic                 valid_q;
    logic [TR_PC_W-1:0]   pc_q, pc_d;
    logic [TR_REG_W-1:0]  reg_q, reg_d;
    logic [TR_DATA_W-1:0] data_q, data_d;
    logic [XLEN-1:0]      retire_q, retire_d, write_q, write_d;

    // Record fields only move on a committed write; counters wrap freely.
    always_comb begin
        pc_d     = we_i ? pc_i : pc_q;
        reg_d    = we_i ? a3_i : reg_q;
        data_d   = we_i ? wd_i : data_q;
        retire_d = retire_q + XLEN'(pc_i != '0);
        write_d  = write_q + XLEN'(we_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            reg_q    <= '0;
            data_q   <= '0;
            retire_q <= '0;
            write_q  <= '0;
        end else begin
            valid_q  <= we_i;
            pc_q     <= pc_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            retire_q <= retire_d;
            write_q  <= write_d;
        end
    end

    assign tr_valid_o   = valid_q;
    assign tr_pc_o      = pc_q;
    assign tr_reg_o     = reg_q;
    assign tr_data_o    = data_q;
    assign retire_cnt_o = retire_q;
    assign write_cnt_o  = write_q;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 GPR file with W->D bypass on both read ports plus retire trace.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      PCW,
    input  logic [AW-1:0]        A3W,
    input  logic [XLEN-1:0]      WDW,
    input  logic [AW-1:0]        A1D,
    input  logic [AW-1:0]        A2D,
    output logic [XLEN-1:0]      RD1D,
    output logic [XLEN-1:0]      RD2D,
    input  logic [AW-1:0]        DbgA,
    output logic [XLEN-1:0]      DbgRD,
    output logic                 TrValid,
    output logic [TR_PC_W-1:0]   TrPC,
    output logic [TR_REG_W-1:0]  TrReg,
    output logic [TR_DATA_W-1:0] TrData,
    output logic [XLEN-1:0]      RetireCnt,
    output logic [XLEN-1:0]      WriteCnt
);
    // The base PC is trace metadata only; an unaligned value is a build error.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("wb_regfile: RESET_PC must be word aligned");
    end

    logic [XLEN-1:0] grf_q [NREGS];
    logic            we;

    assign we = (A3W != REG_ZERO);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) grf_q[i] <= '0;
        end else if (we) begin
            grf_q[A3W] <= WDW;
        end
    end

    always_comb begin
        RD1D  = (A1D == REG_ZERO) ? '0 : (A1D == A3W) ? WDW : grf_q[A1D];
        RD2D  = (A2D == REG_ZERO) ? '0 : (A2D == A3W) ? WDW : grf_q[A2D];
        DbgRD = (DbgA == REG_ZERO) ? '0 : grf_q[DbgA];
    end

    wb_trace u_trace (
        .clk          (clk),
        .reset        (reset),
        .pc_i         (PCW),
        .a3_i         (A3W),
        .wd_i         (WDW),
        .we_i         (we),
        .tr_valid_o   (TrValid),
        .tr_pc_o      (TrPC),
        .tr_reg_o     (TrReg),
        .tr_data_o    (TrData),
        .retire_cnt_o (RetireCnt),
        .write_cnt_o  (WriteCnt)
    );
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Register-file end of the MEM/WB pipeline interface: it consumes the WB-stage bundle (`PCW`, `A3W`, `WDW`) and commits results to the 32×32 general register file. It serves the two D-stage read ports with same-cycle W→D bypass and keeps a registered retire/trace record for bench logging. It sits between the MEM/WB pipeline register and the D-stage operand muxes. A bubble or flushed slot arrives as all-zero (`PCW=0`, `A3W=0`) and must leave no architectural effect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC base; reported in trace only, never used for control.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `PCW`  in  32  PC of the WB instruction; 0 marks a bubble.
- `A3W`  in  5  destination register; 0 means no write.
- `WDW`  in  32  write data.
- `A1D`, `A2D`  in  5 each  D-stage read addresses.
- `RD1D`, `RD2D`  out  32 each  read data, bypassed.
- `DbgA`  in  5  debug read address.
- `DbgRD`  out  32  debug read data, not bypassed.
- `TrValid`  out  1  a register write committed in the previous cycle.
- `TrPC`, `TrReg`, `TrData`  out  32/5/32  trace record of that commit.
- `RetireCnt`  out  32  non-bubble WB slots since reset.
- `WriteCnt`  out  32  committed register writes since reset.

## Operation
- Write enable is `we = (A3W != 0)`. On a posedge with `we` and no reset, `GRF[A3W] <= WDW`.
- `GRF[0]` is always 0. It is never written and reads 0 with no bypass.
- Read path (combinational):
  - `RDnD = (AnD != 0 && AnD == A3W) ? WDW : GRF[AnD]`.
  - When both ports name the same register, both receive the identical value.
- Debug read returns `GRF[DbgA]` (pre-write value in a write cycle).
- Trace: on each posedge, `TrValid <= we` and `TrPC <= PCW`, `TrReg <= A3W`, `TrData <= WDW`.
  - When `we = 0`, the `Tr*` data fields hold their previous values.
  - `TrValid` drops to 0.
- Counters:
  - `RetireCnt` increments when `PCW != 0`.
  - `WriteCnt` increments when `we`.
  - Both wrap modulo 2^32 with no saturation.
- A slot with `PCW != 0` and `A3W = 0` (store, branch) retires without writing.
- A slot with `PCW = 0` and `A3W != 0` is still written and counted in `WriteCnt`. This is a legal but unexpected slot; the bench flags it as a warning.

## Timing
- Write latency: the value is visible in `GRF` after the posedge. In the same cycle it is visible only through the bypass.
- Read latency: 0 cycles (combinational).
- Trace latency: exactly 1 cycle after the commit edge.
- Reset (synchronous):
  - At the posedge with `reset=1`, all 31 registers, both counters, `TrValid`, `TrPC`, `TrReg` and `TrData` go to 0.
  - A write presented in that cycle is dropped and not counted.
  - `RD1D` and `RD2D` still bypass `WDW` combinationally during a reset cycle. Downstream ignores them because D is also being reset.
  - The first cycle after reset deassertion behaves normally.
- Simultaneous events:
  - A write and a read to the same register in one cycle returns the new data.
  - A write and a debug read to the same register in one cycle returns the old data.
  - A write at `RetireCnt = 32'hFFFF_FFFF` wraps the counter to 0.

## Structure
- Shared package constants:
  - `REG_ZERO = 5'd0`.
  - `NREGS = 32`.
  - `XLEN = 32`.
  - Trace record field widths.
- One sub-module, `wb_trace`: holds the `Tr*` registers and both counters. It is driven by `PCW`, `A3W`, `WDW` and `we`.
- The top level holds the register array, write logic and bypass muxes.

## Test plan
- Reset, then read all 32 addresses on both ports and `DbgA` -> all 0. `RetireCnt = WriteCnt = 0` and `TrValid = 0`.
- `A3W=5`, `WDW=32'hDEAD_BEEF`, `PCW=32'h3000`, with `A1D=A2D=5` in the same cycle:
  - same cycle -> `RD1D = RD2D = DEAD_BEEF`, `DbgRD = 0`.
  - next cycle -> `DbgRD = DEAD_BEEF`, `TrValid=1`, `TrPC=3000`, `TrReg=5`, `WriteCnt=1`, `RetireCnt=1`.
- `A3W=0`, `WDW=32'h1234`, `A1D=0` -> `RD1D = 0`, no register changes, `TrValid = 0`. With `PCW=32'h3004` -> `RetireCnt` increments and `WriteCnt` does not.
- A bubble (all inputs zero) for 3 cycles -> no counter changes and `TrValid = 0` throughout.
- Write `r7 = 1`, then assert `reset` in the same cycle as a write `r7 = 2` -> next cycle: `r7 = 0`, `WriteCnt = 0`, `TrValid = 0`.
- Preload `RetireCnt` to `32'hFFFF_FFFF` via a forced value, then retire one slot -> `RetireCnt = 0`.
